// File: rtl/pht_predictor.sv
// pht_predictor
//   Second level of a two-level local branch predictor. A pattern history
//   table (PHT) of 2-bit saturating counters is indexed by
//   {low PC bits, per-branch history}. It produces a registered prediction.
//   Resolved branches train the PHT through a two-stage update pipeline.
//   Stage 0 drives the history-array write port and captures the
//   pre-shift-history index. Stage 1 does the PHT read-modify-write.
//   After reset an INIT sweep writes every entry to weak not-taken.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   pred_valid          prediction request this cycle
//   pred_index          PC index of the branch to predict
//   hist_read_index     history array read index (= pred_index)
//   hist_read           history returned by the array (combinational)
//   pred_out_valid      registered prediction valid
//   pred_taken          registered prediction
//   pred_out_hist       registered history used for the prediction
//   upd_valid           branch resolved this cycle
//   upd_index           PC index of the resolved branch
//   upd_taken           actual outcome
//   upd_pred            prediction issued for this branch
//   hist_write          history array write enable
//   hist_write_index    history array write index (= upd_index)
//   hist_write_in       bit shifted into the history (= upd_taken)
//   hist_write_hist     pre-shift history at hist_write_index
//   init_done           high once the PHT sweep has finished
//   upd_count           saturating count of accepted updates
//   mispredict_count    saturating count of accepted mispredicted updates
module pht_predictor #(
  parameter int width   = 4,
  parameter int length  = 8,
  parameter int pc_bits = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [length-1:0] pred_index,
  output logic [length-1:0] hist_read_index,
  input  logic [width-1:0]  hist_read,
  output logic              pred_out_valid,
  output logic              pred_taken,
  output logic [width-1:0]  pred_out_hist,
  input  logic              upd_valid,
  input  logic [length-1:0] upd_index,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic              hist_write,
  output logic [length-1:0] hist_write_index,
  output logic              hist_write_in,
  input  logic [width-1:0]  hist_write_hist,
  output logic              init_done,
  output logic [15:0]       upd_count,
  output logic [15:0]       mispredict_count
);

  localparam int pht_w = pc_bits + width;
  localparam int depth = 1 << pht_w;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [pht_w-1:0] init_ptr;
  logic [1:0]       pht [depth];

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control FSM: INIT sweeps the whole table once, then RUN forever.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_ptr == '1) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  assign init_done = (state == RUN);

  // ---- stage 0: update capture, history write port, prediction lookup ----
  logic             upd_vld_p0;
  logic [pht_w-1:0] uidx_p0;
  logic [pht_w-1:0] pidx_p0;
  logic [1:0]       pctr_p0;

  logic             upd_vld_p1;
  logic [pht_w-1:0] uidx_p1;
  logic             utaken_p1;
  logic [1:0]       ctr_new_p1;

  assign upd_vld_p0       = upd_valid && (state == RUN);
  assign hist_write       = upd_vld_p0;
  assign hist_write_index = upd_index;
  assign hist_write_in    = upd_taken;
  assign hist_read_index  = pred_index;

  // Pre-shift history forms the training index, so it names the same
  // entry the prediction for this branch was read from.
  assign uidx_p0 = {upd_index[pc_bits-1:0], hist_write_hist};
  assign pidx_p0 = {pred_index[pc_bits-1:0], hist_read};

  // A stage-1 write to the entry being predicted has not landed yet;
  // forward its new value so the prediction is never one update stale.
  assign pctr_p0 = (upd_vld_p1 && (uidx_p1 == pidx_p0)) ? ctr_new_p1 : pht[pidx_p0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_out_valid   <= 1'b0;
      pred_taken       <= 1'b0;
      pred_out_hist    <= '0;
      upd_vld_p1       <= 1'b0;
      upd_count        <= '0;
      mispredict_count <= '0;
    end else begin
      pred_out_valid <= pred_valid;
      pred_taken     <= (state == RUN) && pctr_p0[1];
      pred_out_hist  <= hist_read;
      upd_vld_p1     <= upd_vld_p0;
      if (upd_vld_p0) begin
        upd_count <= sat_inc16(upd_count);
        if (upd_pred != upd_taken) mispredict_count <= sat_inc16(mispredict_count);
      end
    end
  end

  always_ff @(posedge clk) begin
    uidx_p1   <= uidx_p0;
    utaken_p1 <= upd_taken;
  end

  // ---- stage 1: PHT read-modify-write ----
  assign ctr_new_p1 = ctr_next(pht[uidx_p1], utaken_p1);

  // INIT and stage-1 writes never overlap: stage 1 only fills from RUN,
  // and reset clears it before INIT restarts.
  always_ff @(posedge clk) begin
    if (state == INIT)   pht[init_ptr] <= 2'b01;
    else if (upd_vld_p1) pht[uidx_p1]  <= ctr_new_p1;
  end

endmodule

// File: tb/tb_pht_predictor.sv
module tb_pht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [7:0]  pred_index;
  logic [7:0]  hist_read_index;
  logic [3:0]  hist_read;
  logic        pred_out_valid;
  logic        pred_taken;
  logic [3:0]  pred_out_hist;
  logic        upd_valid;
  logic [7:0]  upd_index;
  logic        upd_taken;
  logic        upd_pred;
  logic        hist_write;
  logic [7:0]  hist_write_index;
  logic        hist_write_in;
  logic [3:0]  hist_write_hist;
  logic        init_done;
  logic [15:0] upd_count;
  logic [15:0] mispredict_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_upd = 0;
  int exp_mis = 0;
  int cyc;

  always #5 clk = ~clk;

  pht_predictor #(.width(4), .length(8), .pc_bits(2)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_index(pred_index),
    .hist_read_index(hist_read_index), .hist_read(hist_read),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_out_hist(pred_out_hist),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .hist_write(hist_write),
    .hist_write_index(hist_write_index), .hist_write_in(hist_write_in),
    .hist_write_hist(hist_write_hist), .init_done(init_done),
    .upd_count(upd_count), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One update cycle; leaves upd_valid low afterwards so calls chain back-to-back.
  task automatic do_upd(input logic [7:0] idx, input logic [3:0] hist,
                        input logic taken, input logic pred);
    upd_valid = 1'b1; upd_index = idx; hist_write_hist = hist;
    upd_taken = taken; upd_pred = pred;
    exp_upd = (exp_upd == 65535) ? exp_upd : exp_upd + 1;
    if (taken != pred) exp_mis = (exp_mis == 65535) ? exp_mis : exp_mis + 1;
    tick();
    upd_valid = 1'b0;
  endtask

  // One prediction request; registered outputs are valid on return.
  task automatic do_pred(input logic [7:0] idx, input logic [3:0] hist);
    pred_valid = 1'b1; pred_index = idx; hist_read = hist;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag, input int expect_cycles);
    cyc = 0;
    while (!init_done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk(tag, cyc, expect_cycles);
  endtask

  initial begin
    rst = 1'b1; pred_valid = 0; pred_index = 0; hist_read = 0;
    upd_valid = 0; upd_index = 0; upd_taken = 0; upd_pred = 0; hist_write_hist = 0;
    tick(); tick();
    chk("rst_pov", pred_out_valid, 0);
    chk("rst_ptk", pred_taken, 0);
    chk("rst_phist", pred_out_hist, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_updcnt", upd_count, 0);
    chk("rst_miscnt", mispredict_count, 0);

    // INIT: request a prediction and an update in the first INIT cycle.
    rst = 1'b0;
    pred_valid = 1; pred_index = 8'h05; hist_read = 4'h0;
    upd_valid = 1; upd_index = 8'h05; upd_taken = 1; upd_pred = 0;
    #1;
    chk("init_hist_write", hist_write, 0);
    chk("hist_read_index", hist_read_index, 8'h05);
    cyc = 0;
    tick(); cyc++;
    chk("init_pov", pred_out_valid, 1);
    chk("init_ptk", pred_taken, 0);
    pred_valid = 0; upd_valid = 0;
    while (!init_done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("init_cycles", cyc, 64);
    chk("init_updcnt", upd_count, 0);
    chk("init_miscnt", mispredict_count, 0);

    // Fresh entry predicts not-taken.
    do_pred(8'h05, 4'h0);
    chk("p0_pov", pred_out_valid, 1);
    chk("p0_ptk", pred_taken, 0);
    chk("p0_hist", pred_out_hist, 0);
    tick();
    chk("idle_pov", pred_out_valid, 0);

    // Two taken updates: entry {01,0000} 01->10->11.
    upd_valid = 1; upd_index = 8'h05; upd_taken = 1; upd_pred = 0; hist_write_hist = 0;
    #1;
    chk("run_hist_write", hist_write, 1);
    chk("run_hw_index", hist_write_index, 8'h05);
    chk("run_hw_in", hist_write_in, 1);
    do_upd(8'h05, 4'h0, 1, 0);
    do_upd(8'h05, 4'h0, 1, 1);
    tick();
    do_pred(8'h05, 4'h0);
    chk("trained_taken", pred_taken, 1);
    chk("stat_upd_a", upd_count, exp_upd);
    chk("stat_mis_a", mispredict_count, exp_mis);

    // Three not-taken: 11->10->01->00, then one more stays at 00.
    do_upd(8'h05, 4'h0, 0, 1);
    do_upd(8'h05, 4'h0, 0, 0);
    do_upd(8'h05, 4'h0, 0, 0);
    tick();
    do_pred(8'h05, 4'h0);
    chk("nt_after3", pred_taken, 0);
    do_upd(8'h05, 4'h0, 0, 0);
    tick();
    do_pred(8'h05, 4'h0);
    chk("nt_floor", pred_taken, 0);
    // From 00 one taken update gives 01 (still not-taken).
    do_upd(8'h05, 4'h0, 1, 1);
    tick();
    do_pred(8'h05, 4'h0);
    chk("nt_floor_inc", pred_taken, 0);
    chk("stat_upd_b", upd_count, exp_upd);
    chk("stat_mis_b", mispredict_count, exp_mis);

    // Bypass: update entry {10,0011}, predict it the very next cycle.
    do_upd(8'h06, 4'h3, 1, 1);
    do_pred(8'h06, 4'h3);
    chk("bypass_taken", pred_taken, 1);
    chk("bypass_hist", pred_out_hist, 4'h3);

    // Low PC bits alias: index 0x45 maps to the same entry as 0x05 (01 -> pred 0),
    // while 0x46/hist 3 aliases the trained entry above (10 -> pred 1).
    do_pred(8'h46, 4'h3);
    chk("alias_taken", pred_taken, 1);

    // Statistics saturate after 70000 mispredicting updates.
    upd_valid = 1; upd_index = 8'h07; hist_write_hist = 4'h0; upd_taken = 1; upd_pred = 0;
    repeat (70000) @(posedge clk);
    #1;
    upd_valid = 0;
    chk("sat_upd", upd_count, 16'hFFFF);
    chk("sat_mis", mispredict_count, 16'hFFFF);
    do_upd(8'h07, 4'h0, 1, 1);
    chk("sat_upd_hold", upd_count, 16'hFFFF);

    // Reset mid-RUN with a stage-1 write in flight to entry {01,0101}.
    pred_valid = 1; pred_index = 8'h06; hist_read = 4'h3;
    do_upd(8'h09, 4'h5, 1, 0);
    pred_valid = 0;
    chk("pre_rst_ptk", pred_taken, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pov", pred_out_valid, 0);
    chk("mid_rst_ptk", pred_taken, 0);
    chk("mid_rst_phist", pred_out_hist, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_updcnt", upd_count, 0);
    chk("mid_rst_miscnt", mispredict_count, 0);
    tick();
    rst = 1'b0;
    wait_init("reinit_cycles", 64);
    do_pred(8'h09, 4'h5);
    chk("reinit_entry", pred_taken, 0);
    do_pred(8'h06, 4'h3);
    chk("reinit_trained", pred_taken, 0);
    // One taken update moves 01 -> 10: predicts taken.
    do_upd(8'h09, 4'h5, 1, 0);
    tick();
    do_pred(8'h09, 4'h5);
    chk("reinit_train", pred_taken, 1);
    chk("reinit_updcnt", upd_count, 1);
    chk("reinit_miscnt", mispredict_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
